// File: rtl/exmem_elastic_reg.sv
`default_nettype none
// ============================================================================
// Module  : exmem_elastic_reg
// Brief   : Elastic EX/MEM pipeline register, two-entry skid buffer,
//           flush, bubble zeroing and saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module exmem_elastic_reg #(
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [M_W-1:0]    in_m,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [M_W-1:0]    out_m,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding is {skid_valid, main_valid}
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_in_ready;

  logic [WB_W-1:0]   r_main_wb;
  logic [M_W-1:0]    r_main_m;
  logic [DATA_W-1:0] r_main_alu;
  logic [DATA_W-1:0] r_main_wdata;
  logic [RD_W-1:0]   r_main_rd;

  logic [WB_W-1:0]   r_skid_wb;
  logic [M_W-1:0]    r_skid_m;
  logic [DATA_W-1:0] r_skid_alu;
  logic [DATA_W-1:0] r_skid_wdata;
  logic [RD_W-1:0]   r_skid_rd;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main;
  logic w_load_skid;
  logic w_move_skid;
  logic w_main_drop;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_state[0] && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_move_skid = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_load_main = 1'b1;
            w_state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_move_skid = 1'b1;
            w_state_nxt = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Control fields are zeroed in the register itself so bubbles stay register outputs
  assign w_main_drop = (w_state_nxt == S_EMPTY);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= !w_state_nxt[1];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_main_wb    <= '0;
      r_main_m     <= '0;
      r_main_alu   <= '0;
      r_main_wdata <= '0;
      r_main_rd    <= '0;
    end else if (w_load_main) begin
      r_main_wb    <= in_wb;
      r_main_m     <= in_m;
      r_main_alu   <= in_alu;
      r_main_wdata <= in_wdata;
      r_main_rd    <= in_rd;
    end else if (w_move_skid) begin
      r_main_wb    <= r_skid_wb;
      r_main_m     <= r_skid_m;
      r_main_alu   <= r_skid_alu;
      r_main_wdata <= r_skid_wdata;
      r_main_rd    <= r_skid_rd;
    end else if (w_main_drop) begin
      r_main_wb    <= '0;
      r_main_m     <= '0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_skid_wb    <= '0;
      r_skid_m     <= '0;
      r_skid_alu   <= '0;
      r_skid_wdata <= '0;
      r_skid_rd    <= '0;
    end else if (w_load_skid) begin
      r_skid_wb    <= in_wb;
      r_skid_m     <= in_m;
      r_skid_alu   <= in_alu;
      r_skid_wdata <= in_wdata;
      r_skid_rd    <= in_rd;
    end
  end

  // Only reset clears the counter; flush leaves the history intact
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_state[0] && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[0];
  assign out_wb    = r_main_wb;
  assign out_m     = r_main_m;
  assign out_alu   = r_main_alu;
  assign out_wdata = r_main_wdata;
  assign out_rd    = r_main_rd;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/exmem_elastic_reg.md
# exmem_elastic_reg

Parametrised, elastic successor to the fixed EX/MEM pipeline latch. Carries the write-back control, memory control, ALU result, store data and destination register from EX to MEM. Uses a valid/ready handshake with a two-entry skid buffer, so back-pressure from MEM does not combinationally reach EX. Adds synchronous flush, bubble zeroing of control fields, and a saturating stall counter for performance monitoring.

## Interface
Parameters:
- WB_W, 2, write-back control field width
- M_W, 3, memory control field width
- DATA_W, 32, ALU result and store-data width
- RD_W, 5, destination register index width
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush; drops all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_wb  in  WB_W  write-back control
- in_m  in  M_W  memory control
- in_alu  in  DATA_W  ALU result
- in_wdata  in  DATA_W  store data
- in_rd  in  RD_W  destination register
- out_valid  out  1  main entry valid
- out_ready  in  1  MEM accepts output this cycle
- out_wb  out  WB_W  main entry write-back control; 0 when !out_valid
- out_m  out  M_W  main entry memory control; 0 when !out_valid
- out_alu  out  DATA_W  main entry ALU result
- out_wdata  out  DATA_W  main entry store data
- out_rd  out  RD_W  main entry destination register
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Two storage slots: main (drives outputs) and skid. Each slot holds payload {wb, m, alu, wdata, rd} and a valid bit.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (0,0): on in_fire, load main -> ONE.
  - ONE (0,1):
    - in_fire && out_fire: load main -> ONE.
    - in_fire && !out_fire: load skid -> FULL.
    - !in_fire && out_fire -> EMPTY.
  - FULL (1,1): in_ready=0. On out_fire, skid moves to main -> ONE.
- (1,0) is illegal and never reached.
- Bubble semantics: out_wb and out_m are forced to 0 whenever out_valid=0, so a downstream stage ignoring out_valid sees a NOP.
- out_alu, out_wdata and out_rd hold their last loaded value while invalid.
- flush has priority over every other event. Next state is EMPTY, and in_fire in the same cycle is discarded. The payload registers need not be cleared.
- stall_cnt increments when out_valid && !out_ready, holds at 2^CNT_W-1, and is cleared only by rst. flush does not clear it.

## Timing
- Reset values: out_valid=0, in_ready=1, stall_cnt=0, and out_wb, out_m, out_alu, out_wdata, out_rd all 0. Reset asserted mid-operation drops all entries immediately.
- Latency: data accepted at edge N appears on the outputs after edge N, i.e. valid in cycle N+1.
- Throughput: one transfer per cycle when out_ready is held high.
- in_ready is a register output with no combinational path from out_ready. out_valid and the payload outputs are also register outputs.
- Handshake: producer holds in_valid and the payload stable until in_fire. The stage holds out_valid and the payload stable until out_fire, unless flushed.
- Ordering is strictly FIFO across the two slots; no entry is dropped or duplicated except by flush.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> out_valid=0, in_ready=1, stall_cnt=0, all payload outputs 0, before the next edge.
- Streaming: out_ready=1, 8 back-to-back inputs with alu=1..8 -> out_alu=1..8 on consecutive cycles, one cycle late. stall_cnt stays 0.
- Back-pressure:
  - Drive out_ready=0 while sending alu=0xA, then 0xB -> after two accepts, in_ready=0 and out_alu=0xA is held.
  - Raise out_ready -> 0xA then 0xB emerge in order.
  - stall_cnt equals the number of stalled cycles.
- Flush in FULL:
  - Assert flush with in_valid=1 and in_wb=2'b11 -> next cycle out_valid=0, out_wb=0, out_m=0, in_ready=1.
  - The flushed input never appears at the outputs.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
- Random: random in_valid/out_ready at 50% plus sparse flush, checked against a scoreboard model -> no loss or duplication outside flush, and ordering preserved.
